// File: rtl/multi_cycle_ctrl_if.sv
// Memory handshake between the multi-cycle sequencer and the shared
// instruction/data memory.
//   MemReq    - access request, held until mem_ready
//   MemWrite  - write access, valid with MemReq
//   IorD      - address select: 0 = PC, 1 = ALU result
//   mem_ready - memory completes the current access this cycle
// master: sequencer side, slave: memory side.
interface multi_cycle_ctrl_if;
   logic MemReq;
   logic MemWrite;
   logic IorD;
   logic mem_ready;

   modport master (
      output MemReq,
      output MemWrite,
      output IorD,
      input  mem_ready
   );

   modport slave (
      input  MemReq,
      input  MemWrite,
      input  IorD,
      output mem_ready
   );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle sequencer for the 4-bit-opcode datapath (R-type, lw, sw, beq).
// Walks FETCH/DECODE/EXEC/MEM/WB, drives the datapath mux selects and write
// strobes, and traps on illegal opcodes or a memory that never answers.
// Ports:
//   clk, rst_n    - rising-edge clock, asynchronous active-low reset
//   start         - leave IDLE and begin fetching
//   halt_req      - return to IDLE at the next instruction boundary
//   opcode        - IR[15:12], sampled in DECODE
//   memBus        - req/ready memory handshake (master side)
//   IrWrite .. AluOp - datapath strobes and mux selects
//   busy, fault   - status; fault_code 01 = illegal opcode, 10 = mem timeout
//   instr_count   - retired instruction counter, wraps
module multi_cycle_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 halt_req,
   input  logic [3:0]           opcode,
   multi_cycle_ctrl_if.master   memBus,
   output logic                 IrWrite,
   output logic                 PcWrite,
   output logic                 PcWriteCond,
   output logic                 RegWrite,
   output logic                 RegDst,
   output logic                 MemToReg,
   output logic                 AluSrcA,
   output logic [1:0]           AluSrcB,
   output logic                 extOp,
   output logic [2:0]           AluOp,
   output logic                 busy,
   output logic                 fault,
   output logic [1:0]           fault_code,
   output logic [CNT_W-1:0]     instr_count
);

   localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

   localparam logic [3:0] OpR   = 4'b0000;
   localparam logic [3:0] OpLw  = 4'b0001;
   localparam logic [3:0] OpSw  = 4'b0010;
   localparam logic [3:0] OpBeq = 4'b0011;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StFault
   } stateT;

   stateT             stateQ;
   logic [3:0]        opQ;
   logic [WaitW-1:0]  waitCnt;
   logic [CNT_W-1:0]  instrCnt;
   logic [1:0]        faultCode;
   logic              haltPend;

   logic memReq, memWrite, iorD;
   logic ready;
   logic retire;
   logic haltNow;

   assign ready = memBus.mem_ready;

   // An instruction retires in its last cycle: beq in EXEC, sw when its MEM
   // access completes, R-type/lw in WB.
   assign retire = ((stateQ == StExec) && (opQ == OpBeq)) ||
                   ((stateQ == StMem) && ready && (opQ == OpSw)) ||
                   (stateQ == StWb);

   // A halt request seen anywhere inside an instruction is remembered so a
   // short pulse still stops the sequencer at the boundary.
   assign haltNow = halt_req | haltPend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= StIdle;
         opQ       <= 4'b0000;
         waitCnt   <= '0;
         instrCnt  <= '0;
         faultCode <= 2'b00;
         haltPend  <= 1'b0;
      end else begin
         // Counter only runs while an access is stalled; any other cycle
         // leaves it at zero so it is clear on entry to FETCH/MEM.
         waitCnt <= '0;

         if (busy && halt_req) begin
            haltPend <= 1'b1;
         end
         if (retire) begin
            instrCnt <= instrCnt + CNT_W'(1);
            haltPend <= 1'b0;
         end

         case (stateQ)
            StIdle: begin
               if (start) begin
                  stateQ <= StFetch;
               end
            end
            StFetch: begin
               if (ready) begin
                  stateQ <= StDecode;
               end else if (waitCnt == WaitLast) begin
                  stateQ    <= StFault;
                  faultCode <= 2'b10;
               end else begin
                  waitCnt <= waitCnt + WaitW'(1);
               end
            end
            StDecode: begin
               opQ <= opcode;
               if (opcode <= OpBeq) begin
                  stateQ <= StExec;
               end else begin
                  stateQ    <= StFault;
                  faultCode <= 2'b01;
               end
            end
            StExec: begin
               case (opQ)
                  OpR:        stateQ <= StWb;
                  OpLw, OpSw: stateQ <= StMem;
                  OpBeq:      stateQ <= haltNow ? StIdle : StFetch;
                  default:    stateQ <= StFault;
               endcase
            end
            StMem: begin
               if (ready) begin
                  if (opQ == OpSw) begin
                     stateQ <= haltNow ? StIdle : StFetch;
                  end else begin
                     stateQ <= StWb;
                  end
               end else if (waitCnt == WaitLast) begin
                  stateQ    <= StFault;
                  faultCode <= 2'b10;
               end else begin
                  waitCnt <= waitCnt + WaitW'(1);
               end
            end
            StWb: begin
               stateQ <= haltNow ? StIdle : StFetch;
            end
            StFault: begin
               stateQ <= StFault;
            end
            default: begin
               stateQ <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      memReq      = 1'b0;
      memWrite    = 1'b0;
      iorD        = 1'b0;
      IrWrite     = 1'b0;
      PcWrite     = 1'b0;
      PcWriteCond = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemToReg    = 1'b0;
      AluSrcA     = 1'b0;
      AluSrcB     = 2'b00;
      extOp       = 1'b0;
      AluOp       = 3'b000;
      case (stateQ)
         StFetch: begin
            memReq = 1'b1;
            if (ready) begin
               // PC + 1 written back while the instruction lands in IR
               IrWrite = 1'b1;
               PcWrite = 1'b1;
               AluSrcB = 2'b01;
               AluOp   = 3'b001;
            end
         end
         StDecode: begin
            // Speculative branch target into ALUOut
            AluSrcB = 2'b11;
            extOp   = 1'b1;
            AluOp   = 3'b001;
         end
         StExec: begin
            AluSrcA = 1'b1;
            case (opQ)
               OpR: begin
                  AluOp = 3'b100;
               end
               OpLw, OpSw: begin
                  AluSrcB = 2'b10;
                  extOp   = 1'b1;
                  AluOp   = 3'b001;
               end
               OpBeq: begin
                  AluOp       = 3'b010;
                  PcWriteCond = 1'b1;
               end
               default: begin
                  AluSrcA = 1'b0;
               end
            endcase
         end
         StMem: begin
            memReq   = 1'b1;
            iorD     = 1'b1;
            memWrite = (opQ == OpSw);
         end
         StWb: begin
            RegWrite = 1'b1;
            RegDst   = (opQ == OpR);
            MemToReg = (opQ == OpLw);
         end
         default: begin
         end
      endcase
   end

   assign memBus.MemReq   = memReq;
   assign memBus.MemWrite = memWrite;
   assign memBus.IorD     = iorD;

   assign busy        = (stateQ != StIdle) && (stateQ != StFault);
   assign fault       = (stateQ == StFault);
   assign fault_code  = faultCode;
   assign instr_count = instrCnt;

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle sequencer for the 4-bit-opcode datapath: R-type 0000, lw 0001, sw 0010, beq 0011.
- Replaces single-cycle decode with an FSM: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- Drives the datapath mux/write strobes and a req/ready memory handshake shared by instruction and data accesses.
- Adds a memory-wait timeout, illegal-opcode trap and a retired-instruction counter.

Parameters:
- TIMEOUT, 16: maximum consecutive mem_ready-low cycles in FETCH or MEM before fault. Legal range ≥2.
- CNT_W, 16: width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- halt_req  in  1  stop at the next instruction boundary.
- opcode  in  4  IR[15:12] from datapath, valid in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  write access (valid with MemReq).
- IorD  out  1  0 = PC address, 1 = ALU address.
- IrWrite  out  1  load IR.
- PcWrite  out  1  unconditional PC load.
- PcWriteCond  out  1  PC load if ALU zero.
- RegWrite  out  1  register file write.
- RegDst  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = MDR, 0 = ALUOut.
- AluSrcA  out  1  0 = PC, 1 = regA.
- AluSrcB  out  2  00 = regB, 01 = const 1, 10 = ext imm, 11 = ext imm (branch target).
- extOp  out  1  sign-extend immediate.
- AluOp  out  3  001 = add, 010 = sub/compare, 100 = funct-decoded.
- busy  out  1  state not IDLE and not FAULT.
- fault  out  1  in FAULT.
- fault_code  out  2  01 = illegal opcode, 10 = memory timeout.
- instr_count  out  CNT_W  retired instructions.

Behaviour:

Reset (async, rst_n=0):
- State = IDLE, op_q = 0, wait counter = 0, instr_count = 0, fault_code = 00.
- All outputs 0.
- Reset mid-operation aborts immediately; no strobe is emitted after rst_n falls.

Output decode:
- Outputs are combinational from state, op_q and mem_ready. Strobes not listed for a state are 0.
- Strobe gating: IrWrite, PcWrite and FETCH's next-state move are qualified by mem_ready.

IDLE:
- All outputs 0.
- start=1 → FETCH next cycle. Otherwise stay.

FETCH:
- MemReq=1, IorD=0, MemWrite=0.
- mem_ready=1: IrWrite=1, PcWrite=1, AluSrcA=0, AluSrcB=01, AluOp=001 (PC+1) → DECODE.
- mem_ready=0: stay; MemReq is held high until ready.

DECODE:
- Latch op_q=opcode. Drive AluSrcA=0, AluSrcB=11, extOp=1, AluOp=001 (branch target into ALUOut).
- opcode ≤ 0011 → EXEC.
- Otherwise → FAULT with fault_code=01.

EXEC:
- R-type: AluSrcA=1, AluSrcB=00, AluOp=100 → WB.
- lw/sw: AluSrcA=1, AluSrcB=10, extOp=1, AluOp=001 → MEM.
- beq: AluSrcA=1, AluSrcB=00, AluOp=010, PcWriteCond=1 → boundary (instruction retires).

MEM:
- MemReq=1, IorD=1, MemWrite=(op_q==sw). Held stable until mem_ready.
- On ready, sw → boundary (retire); lw → WB.

WB:
- RegWrite=1.
- R-type: RegDst=1, MemToReg=0. lw: RegDst=0, MemToReg=1.
- → boundary (retire).

Boundary:
- instr_count increments by 1 in the cycle the instruction retires; wraps at 2^CNT_W−1 → 0.
- Next state is IDLE if halt_req=1 that cycle, else FETCH.
- halt_req at any other time has no effect until the boundary.

Timeout:
- Wait counter clears on entry to FETCH or MEM.
- It increments each cycle in FETCH/MEM with mem_ready=0.
- If counter==TIMEOUT−1 and mem_ready=0 → FAULT with fault_code=10.
- mem_ready=1 in that same cycle wins: the access completes and there is no fault.

FAULT:
- fault=1, busy=0, all other strobes 0, fault_code held.
- Exits only via reset. start is ignored.

General:
- mem_ready is ignored outside FETCH and MEM.
- Latencies with zero wait states: R-type 4 cycles, lw 5, sw 4, beq 3.

Test Plan:
- Reset, then start=1; mem_ready always 1; R-type (opcode 0000) → states FETCH, DECODE, EXEC, WB; RegWrite=1 with RegDst=1 only in the WB cycle; instr_count=1 after 4 cycles.
- lw with mem_ready low 3 cycles in MEM → MemReq=1, IorD=1, MemWrite=0 held for 4 cycles; then WB with MemToReg=1, RegDst=0; total 8 cycles; count +1.
- sw then beq back-to-back, zero wait → sw: MemWrite=1 for exactly 1 MEM cycle, no RegWrite; beq: PcWriteCond=1 in EXEC only; count +2 after 7 cycles.
- opcode 0111 in DECODE → FAULT next cycle, fault=1, fault_code=01, busy=0; start pulses ignored; rst_n low → IDLE, all outputs 0.
- TIMEOUT=16, mem_ready held low in FETCH → FAULT after exactly 16 FETCH cycles, fault_code=10. Rerun with mem_ready=1 on the 16th cycle → DECODE, no fault.
- halt_req pulsed during EXEC of R-type → WB completes, then IDLE; count +1. Separately, rst_n asserted mid-MEM → outputs 0 asynchronously and instr_count=0.
